// File: rtl/intersection_controller.sv
// Traffic-light controller cycling GREEN -> YELLOW -> ALLRED across NUM_DIR approaches.
// Define DEMAND_SKIP_EN to skip directions without demand and hold green when nobody waits.
module intersection_controller #(
  parameter int unsigned NUM_DIR     = 4,
  parameter int unsigned TIMER_W     = 7,
  parameter int unsigned GREEN_TIME  = 30,
  parameter int unsigned YELLOW_TIME = 5,
  parameter int unsigned ALLRED_TIME = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               enable,
  input  logic [NUM_DIR-1:0] demand,
  output logic [NUM_DIR-1:0] green_light,
  output logic [NUM_DIR-1:0] yellow_light,
  output logic [NUM_DIR-1:0] red_light,
  output logic [2:0]         active_dir,
  output logic [TIMER_W-1:0] master_timer
);

  typedef enum logic [1:0] {IDLE, ALLRED, GREEN, YELLOW} state_t;

  localparam logic [TIMER_W-1:0] T_GREEN  = TIMER_W'(GREEN_TIME);
  localparam logic [TIMER_W-1:0] T_YELLOW = TIMER_W'(YELLOW_TIME);
  localparam logic [TIMER_W-1:0] T_ALLRED = TIMER_W'(ALLRED_TIME);
  localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);

  state_t               state_q, state_d;
  logic [2:0]           dir_q, dir_d;
  logic [2:0]           nxt_q, nxt_d;
  logic                 adv_q, adv_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [NUM_DIR-1:0]   green_q, yellow_q, red_q;
  logic [NUM_DIR-1:0]   green_d, yellow_d, lamp_d;

  function automatic logic [2:0] succ(input logic [2:0] d);
    return (d == 3'(NUM_DIR - 1)) ? 3'd0 : d + 3'd1;
  endfunction

`ifdef DEMAND_SKIP_EN
  logic       skip_found;
  logic [2:0] skip_dir;

  always_comb begin
    logic [7:0] dem8;
    logic [2:0] cand;
    dem8       = 8'(demand);
    skip_found = 1'b0;
    skip_dir   = dir_q;
    cand       = dir_q;
    for (int unsigned k = 1; k < NUM_DIR; k++) begin
      cand = succ(cand);
      if (!skip_found && dem8[cand]) begin
        skip_found = 1'b1;
        skip_dir   = cand;
      end
    end
  end
`else
  logic unused_demand;
  assign unused_demand = ^demand;
`endif

  // adv_q separates a resume from IDLE (serve same direction) from a normal rotation.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    nxt_d   = nxt_q;
    adv_d   = adv_q;
    timer_d = timer_q;
    if (!enable) begin
      state_d = IDLE;
      timer_d = '0;
    end else if (state_q == IDLE) begin
      state_d = ALLRED;
      timer_d = T_ALLRED;
      adv_d   = 1'b0;
    end else if (tick) begin
      if (timer_q != T_ONE) begin
        timer_d = timer_q - T_ONE;
      end else if (state_q == ALLRED) begin
        state_d = GREEN;
        timer_d = T_GREEN;
        if (adv_q) dir_d = nxt_q;
      end else if (state_q == GREEN) begin
`ifdef DEMAND_SKIP_EN
        if (skip_found) begin
          state_d = YELLOW;
          timer_d = T_YELLOW;
          nxt_d   = skip_dir;
        end else begin
          timer_d = T_GREEN;
        end
`else
        state_d = YELLOW;
        timer_d = T_YELLOW;
        nxt_d   = succ(dir_q);
`endif
      end else begin
        state_d = ALLRED;
        timer_d = T_ALLRED;
        adv_d   = 1'b1;
      end
    end
  end

  always_comb begin
    lamp_d   = {{(NUM_DIR-1){1'b0}}, 1'b1} << dir_d;
    green_d  = (state_d == GREEN)  ? lamp_d : '0;
    yellow_d = (state_d == YELLOW) ? lamp_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dir_q    <= '0;
      nxt_q    <= '0;
      adv_q    <= 1'b0;
      timer_q  <= '0;
      green_q  <= '0;
      yellow_q <= '0;
      red_q    <= '1;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      nxt_q    <= nxt_d;
      adv_q    <= adv_d;
      timer_q  <= timer_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= ~(green_d | yellow_d);
    end
  end

  assign green_light  = green_q;
  assign yellow_light = yellow_q;
  assign red_light    = red_q;
  assign active_dir   = dir_q;
  assign master_timer = timer_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed self-checking bench for intersection_controller (NUM_DIR=4, default timings).
module tb_intersection_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       enable;
  logic [3:0] demand;
  logic [3:0] green_light, yellow_light, red_light;
  logic [2:0] active_dir;
  logic [6:0] master_timer;

  int errors = 0;
  int checks = 0;

`ifdef DEMAND_SKIP_EN
  localparam logic [3:0] DEM = 4'b1111;
`else
  localparam logic [3:0] DEM = 4'b0100;
`endif

  intersection_controller #(
    .NUM_DIR(4), .TIMER_W(7), .GREEN_TIME(30), .YELLOW_TIME(5), .ALLRED_TIME(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable), .demand(demand),
    .green_light(green_light), .yellow_light(yellow_light), .red_light(red_light),
    .active_dir(active_dir), .master_timer(master_timer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic lamps_sane();
    check("lamp_cover", 32'(green_light | yellow_light | red_light), 32'hF);
    check("lamp_excl", 32'((green_light & yellow_light) | (green_light & red_light) |
                           (yellow_light & red_light)), 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    lamps_sane();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] y,
                            input logic [3:0] r, input int d, input int t);
    check({tag, "_green"},  32'(green_light),  32'(g));
    check({tag, "_yellow"}, 32'(yellow_light), 32'(y));
    check({tag, "_red"},    32'(red_light),    32'(r));
    check({tag, "_dir"},    32'(active_dir),   32'(d));
    check({tag, "_timer"},  32'(master_timer), 32'(t));
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    tick   = 1'b0;
    demand = DEM;
    #22;
    expect_out("reset", 4'h0, 4'h0, 4'hF, 0, 0);

    @(posedge clk); #1;
    rst_n = 1'b1; enable = 1'b1; tick = 1'b1;
    step(); expect_out("allred1", 4'h0, 4'h0, 4'hF, 0, 2);
    step(); expect_out("allred2", 4'h0, 4'h0, 4'hF, 0, 1);
    step(); expect_out("d0_green", 4'h1, 4'h0, 4'hE, 0, 30);
    run(29); expect_out("d0_green_end", 4'h1, 4'h0, 4'hE, 0, 1);
    step(); expect_out("d0_yellow", 4'h0, 4'h1, 4'hE, 0, 5);
    run(5); expect_out("d0_allred", 4'h0, 4'h0, 4'hF, 0, 2);
    run(2); expect_out("d1_green", 4'h2, 4'h0, 4'hD, 1, 30);
    run(18); expect_out("d1_t12", 4'h2, 4'h0, 4'hD, 1, 12);

    tick = 1'b0;
    run(100); expect_out("tick_hold", 4'h2, 4'h0, 4'hD, 1, 12);

    tick = 1'b1; enable = 1'b0;
    step(); expect_out("disable", 4'h0, 4'h0, 4'hF, 1, 0);
    step(); expect_out("disable_hold", 4'h0, 4'h0, 4'hF, 1, 0);
    enable = 1'b1;
    step(); expect_out("reen_allred", 4'h0, 4'h0, 4'hF, 1, 2);
    step(); expect_out("reen_allred2", 4'h0, 4'h0, 4'hF, 1, 1);
    step(); expect_out("reen_green", 4'h2, 4'h0, 4'hD, 1, 30);
    run(30); expect_out("d1_yellow", 4'h0, 4'h2, 4'hD, 1, 5);
    run(7); expect_out("d2_green", 4'h4, 4'h0, 4'hB, 2, 30);
    run(37); expect_out("d3_green", 4'h8, 4'h0, 4'h7, 3, 30);
    run(30); expect_out("d3_yellow", 4'h0, 4'h8, 4'h7, 3, 5);
    run(6); expect_out("d3_allred", 4'h0, 4'h0, 4'hF, 3, 1);
    step(); expect_out("wrap_d0", 4'h1, 4'h0, 4'hE, 0, 30);
    run(37); expect_out("d1_green_b", 4'h2, 4'h0, 4'hD, 1, 30);
    run(32); expect_out("d1_yellow_mid", 4'h0, 4'h2, 4'hD, 1, 3);

    #2 rst_n = 1'b0;
    #1 expect_out("async_rst", 4'h0, 4'h0, 4'hF, 0, 0);
    lamps_sane();

`ifdef DEMAND_SKIP_EN
    demand = 4'b0000;
    #3 rst_n = 1'b1;
    run(3); expect_out("skip_d0_green", 4'h1, 4'h0, 4'hE, 0, 30);
    run(30); expect_out("skip_hold", 4'h1, 4'h0, 4'hE, 0, 30);
    demand = 4'b1000;
    run(30); expect_out("skip_yellow", 4'h0, 4'h1, 4'hE, 0, 5);
    run(5); expect_out("skip_allred", 4'h0, 4'h0, 4'hF, 0, 2);
    run(2); expect_out("skip_d3", 4'h8, 4'h0, 4'h7, 3, 30);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
